// File: rtl/seq_det_pkg.sv
// Shared types and defaults for the sequence-detect scheduler.
// State encoding, default geometry and counter sizing helper.
package seq_det_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    REPORT = 2'd2
  } state_t;

  localparam int         DEF_W   = 16;
  localparam int         DEF_PW  = 8;
  localparam logic [7:0] DEF_PAT = 8'b0101_0101;

  // Bits needed to hold 0..(w-pw+1) matches.
  function automatic int cnt_width(input int w, input int pw);
    return $clog2(w - pw + 2);
  endfunction

endpackage

// File: rtl/seq_det_core.sv
// Serial pattern detector: shifts one bit per enabled cycle and compares.
// Ports: clk, rst, clr (new word), en, sbit, pattern, armed -> match.
module seq_det_core
  import seq_det_pkg::*;
#(
  parameter int PW = DEF_PW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  input  logic          sbit,
  input  logic [PW-1:0] pattern,
  input  logic          armed,
  output logic          match
);

  // Only PW-1 bits of history are stored; the incoming bit completes the window.
  logic [PW-2:0] hist;
  logic [PW-1:0] nh;

  assign nh    = {hist, sbit};
  assign match = en && armed && (nh == pattern);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      hist <= '0;
    end else if (en) begin
      hist <= nh[PW-2:0];
    end
  end

endmodule

// File: rtl/seq_det_scheduler.sv
// Round-robin share of one serial detector between two word requesters.
// Ports: req0/req1 valid/data/ready, cfg_we/cfg_pat, busy, res_valid/id/count/hit.
module seq_det_scheduler
  import seq_det_pkg::*;
#(
  parameter int          W   = DEF_W,
  parameter int          PW  = DEF_PW,
  parameter logic [PW-1:0] PAT = PW'(DEF_PAT),
  parameter int          CW  = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid,
  input  logic [W-1:0]  req0_data,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [W-1:0]  req1_data,
  output logic          req1_ready,
  input  logic          cfg_we,
  input  logic [PW-1:0] cfg_pat,
  output logic          busy,
  output logic          res_valid,
  output logic          res_id,
  output logic [CW-1:0] res_count,
  output logic          res_hit
);

  localparam int IW = $clog2(W);
  localparam logic [IW-1:0] LAST = IW'(W - 1);
  localparam logic [IW-1:0] ARM  = IW'(PW - 1);

  state_t        state, state_n;
  logic          accept;
  logic          last_id;
  logic          gnt_id;
  logic          cur_id;
  logic [W-1:0]  sr;
  logic [IW-1:0] idx;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;
  logic [PW-1:0] pattern;
  logic          shifting;
  logic          armed;
  logic          match;

  // Contention goes to whoever was not served last.
  assign gnt_id = (req0_valid && req1_valid) ? ~last_id : req1_valid;

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    unique case (state)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          accept  = 1'b1;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        if (idx == LAST) state_n = REPORT;
      end
      REPORT:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  assign req0_ready = accept && !gnt_id;
  assign req1_ready = accept && gnt_id;
  assign busy       = (state != IDLE);
  assign res_valid  = (state == REPORT);

  assign shifting = (state == SHIFT);
  assign armed    = (idx >= ARM);
  assign cnt_n    = cnt + CW'(match);

  seq_det_core #(
    .PW(PW)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .clr     (accept),
    .en      (shifting),
    .sbit    (sr[W-1]),
    .pattern (pattern),
    .armed   (armed),
    .match   (match)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      last_id   <= 1'b1;
      pattern   <= PAT;
      cur_id    <= 1'b0;
      sr        <= '0;
      idx       <= '0;
      cnt       <= '0;
      res_id    <= 1'b0;
      res_count <= '0;
      res_hit   <= 1'b0;
    end else begin
      // Pattern only moves between jobs; a same-cycle accept sees it.
      if (state == IDLE && cfg_we) pattern <= cfg_pat;
      if (accept) begin
        sr      <= gnt_id ? req1_data : req0_data;
        cur_id  <= gnt_id;
        last_id <= gnt_id;
        idx     <= '0;
        cnt     <= '0;
      end else if (shifting) begin
        sr  <= sr << 1;
        idx <= idx + IW'(1);
        cnt <= cnt_n;
        // Results are captured on the last bit and held until the next one.
        if (idx == LAST) begin
          res_id    <= cur_id;
          res_count <= cnt_n;
          res_hit   <= (cnt_n != '0);
        end
      end
    end
  end

endmodule
